// File: rtl/alu8.sv
// alu8: 8-bit ALU with combinational Y/Cout and a registered Z,N,C,V flag register
//   clk, rst_n (async, active-low)  - clock and flag-register reset
//   A, B [7:0], Op [2:0], Cin       - operands, operation select, carry/borrow/shift-in
//   flag_we                         - latch flags from the current result on the next rising clk
//   Y [7:0], Cout                   - combinational result and carry/borrow/shift-out
//   Zf, Nf, Cf, Vf                  - registered zero, negative, carry and overflow flags
module alu8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] Op,
    input  logic       Cin,
    input  logic       flag_we,
    output logic [7:0] Y,
    output logic       Cout,
    output logic       Zf,
    output logic       Nf,
    output logic       Cf,
    output logic       Vf
);
    logic [8:0] sum;
    logic [8:0] diff;
    logic       v;
    logic [3:0] flags_d;
    logic [3:0] flags_q;
    always_comb begin
        sum  = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
        // bit 8 of the 9-bit difference is set exactly when A < B + Cin
        diff = {1'b0, A} - {1'b0, B} - {8'b0, Cin};
        Y    = 8'h00;
        Cout = 1'b0;
        case (Op)
            3'b000:  {Cout, Y} = sum;
            3'b001:  {Cout, Y} = diff;
            3'b010:  Y = A & B;
            3'b011:  Y = A | B;
            3'b100:  Y = A ^ B;
            3'b101:  Y = ~(A & B);
            3'b110:  {Cout, Y} = {A[7], A[6:0], Cin};
            default: {Cout, Y} = {A[0], Cin, A[7:1]};
        endcase
        v = (Op == 3'b000) ? (A[7] == B[7]) && (Y[7] != A[7]) :
            (Op == 3'b001) ? (A[7] != B[7]) && (Y[7] != A[7]) : 1'b0;
        flags_d = flag_we ? {Y == 8'h00, Y[7], Cout, v} : flags_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end
    assign {Zf, Nf, Cf, Vf} = flags_q;
endmodule

// File: tb/tb_alu8.sv
// tb_alu8: randomized and directed check of alu8 against an arithmetic reference model
module tb_alu8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [2:0] Op = 3'b000;
    logic       Cin = 1'b0;
    logic       flag_we = 1'b0;
    logic [7:0] Y;
    logic       Cout, Zf, Nf, Cf, Vf;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] exp_flags = 4'b0000;

    alu8 dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op(Op), .Cin(Cin), .flag_we(flag_we),
        .Y(Y), .Cout(Cout), .Zf(Zf), .Nf(Nf), .Cf(Cf), .Vf(Vf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // returns {v, cout, y} computed with plain integer arithmetic
    function automatic logic [9:0] ref_alu(input int a, input int b, input int op, input int cin);
        int r, c, v;
        c = 0;
        case (op)
            0: begin r = a + b + cin; c = (r > 255); end
            1: begin r = a - b - cin; c = (r < 0); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~(a & b);
            6: begin r = a * 2 + cin; c = a / 128; end
            default: begin r = a / 2 + cin * 128; c = a % 2; end
        endcase
        r = r & 255;
        v = 0;
        if (op == 0) v = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
        if (op == 1) v = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128));
        return {v[0], c[0], r[7:0]};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic cin, input logic we, input logic rst_pulse);
        logic [9:0] m;
        @(negedge clk);
        A = a; B = b; Op = op; Cin = cin; flag_we = we;
        #1;
        m = ref_alu(a, b, op, cin);
        check($sformatf("Y op%0d a%0d b%0d c%0d", op, a, b, cin), Y, m[7:0]);
        check($sformatf("Cout op%0d a%0d b%0d c%0d", op, a, b, cin), Cout, m[8]);
        if (rst_pulse) begin
            rst_n = 1'b0;
            #1;
            exp_flags = 4'b0000;
            check("flags async clear", {Zf, Nf, Cf, Vf}, 0);
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        if (we) exp_flags = {m[7:0] == 8'h00, m[7], m[8], m[9]};
        check($sformatf("flags op%0d we%0d", op, we), {Zf, Nf, Cf, Vf}, exp_flags);
    endtask

    initial begin
        A = 8'd7; B = 8'd8; Op = 3'b000; Cin = 1'b0; flag_we = 1'b1;
        #10;
        check("reset flags", {Zf, Nf, Cf, Vf}, 0);
        check("add in reset Y", Y, 15);
        check("add in reset Cout", Cout, 0);
        @(posedge clk);
        #1;
        check("flags held in reset", {Zf, Nf, Cf, Vf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd200, 8'd100, 3'b000, 1'b1, 1'b0, 1'b0);
        run_op(8'd127, 8'd1,   3'b000, 1'b0, 1'b1, 1'b0);
        check("127+1 Nf", Nf, 1);
        check("127+1 Vf", Vf, 1);
        check("127+1 Zf", Zf, 0);
        run_op(8'd5,   8'd7,   3'b001, 1'b0, 1'b0, 1'b0);
        run_op(8'd7,   8'd7,   3'b001, 1'b0, 1'b1, 1'b0);
        check("7-7 Zf", Zf, 1);
        check("7-7 Cf", Cf, 0);
        for (int o = 2; o < 6; o++) run_op(8'hF0, 8'h3C, o[2:0], 1'b1, 1'b0, 1'b0);
        run_op(8'h81, 8'hFF, 3'b110, 1'b1, 1'b1, 1'b0);
        run_op(8'h81, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0);
        run_op(8'hFF, 8'h00, 3'b000, 1'b1, 1'b1, 1'b0);
        run_op(8'h00, 8'hFF, 3'b001, 1'b1, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 3'b001, 1'b0, 1'b1, 1'b0);
        run_op(8'h12, 8'h34, 3'b010, 1'b0, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 3'b000, 1'b0, 1'b1, 1'b0);
        run_op(8'h55, 8'h55, 3'b100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++)
            run_op(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
                   1'($urandom), ($urandom_range(0, 19) == 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
